// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and frame-timing helpers for the UART
// transmit arbiter.
package uart_pkg;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned TIMER_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Clock cycles per UART bit, matching the transmitter's divider.
  function automatic int unsigned bps_cnt(input int unsigned clk_freq,
                                          input int unsigned bps);
    return clk_freq / bps;
  endfunction

  // Start + 8 data + stop bits, plus margin for the transmitter's
  // two-stage enable edge detector.
  function automatic int unsigned frame_cycles(input int unsigned clk_freq,
                                               input int unsigned bps);
    return 10 * bps_cnt(clk_freq, bps) + 4;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way rotate-priority encoder: the search starts one past the last
// granted index and wraps around.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       gnt_vld,
  output logic [1:0] gnt_id
);
  import uart_pkg::*;

  logic [1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest pending request wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = last;
    w_idx   = '0;
    for (int unsigned off = N_REQ; off >= 1; off--) begin
      w_idx = last + 2'(off);
      if (req[w_idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = w_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_send transmitter among four byte
// producers. The transmitter has no busy output, so frames are timed here.
module uart_tx_arbiter #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned UART_BPS = 9600
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic        uart_en,
  output logic [7:0]  uart_din,
  output logic        busy,
  output logic [1:0]  grant_id
);
  import uart_pkg::*;

  localparam int unsigned FRAME_CYCLES = frame_cycles(CLK_FREQ, UART_BPS);
  localparam logic [TIMER_W-1:0] C_FRAME   = TIMER_W'(FRAME_CYCLES);
  localparam logic [TIMER_W-1:0] C_EN_LAST = TIMER_W'(2);

  if (FRAME_CYCLES >= (1 << TIMER_W)) begin : g_frame_too_long
    $error("uart_tx_arbiter: frame length does not fit the 20-bit frame timer");
  end

  state_t             r_state, w_state_nxt;
  logic [TIMER_W-1:0] r_timer, w_timer_nxt;
  logic [1:0]         r_last,  w_last_nxt;
  logic [1:0]         r_gid,   w_gid_nxt;
  logic [7:0]         r_din,   w_din_nxt;
  logic [3:0]         r_ready, w_ready_nxt;
  logic               r_en,    w_en_nxt;
  logic               r_busy,  w_busy_nxt;

  logic               w_gnt_vld;
  logic [1:0]         w_gnt_id;

  rr_arbiter4 u_rr (
    .req     (req_valid),
    .last    (r_last),
    .gnt_vld (w_gnt_vld),
    .gnt_id  (w_gnt_id)
  );

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_last_nxt  = r_last;
    w_gid_nxt   = r_gid;
    w_din_nxt   = r_din;
    w_en_nxt    = r_en;
    w_busy_nxt  = r_busy;
    w_ready_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld) begin
          w_state_nxt           = ST_START;
          w_din_nxt             = req_data[{w_gnt_id, 3'b000} +: 8];
          w_gid_nxt             = w_gnt_id;
          w_last_nxt            = w_gnt_id;
          w_ready_nxt[w_gnt_id] = 1'b1;
          w_en_nxt              = 1'b1;
          w_busy_nxt            = 1'b1;
          w_timer_nxt           = TIMER_W'(1);
        end
      end
      ST_START: begin
        w_timer_nxt = r_timer + TIMER_W'(1);
        if (r_timer == C_EN_LAST) begin
          w_state_nxt = ST_WAIT;
          w_en_nxt    = 1'b0;
        end
      end
      ST_WAIT: begin
        w_timer_nxt = r_timer + TIMER_W'(1);
        if (r_timer == C_FRAME) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_en_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, timer and output registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_last  <= 2'd3;
      r_gid   <= '0;
      r_din   <= '0;
      r_ready <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_last  <= w_last_nxt;
      r_gid   <= w_gid_nxt;
      r_din   <= w_din_nxt;
      r_ready <= w_ready_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign req_ready = r_ready;
  assign uart_en   = r_en;
  assign uart_din  = r_din;
  assign busy      = r_busy;
  assign grant_id  = r_gid;

endmodule
